// File: rtl/pkt_read_arbiter_if.sv
// Shared packet-RAM read bundle: per-port request/ack/data strobes plus the single RAM read port.
// The slave modport is the arbiter's view; master is the schedulers-plus-RAM side.
interface pkt_read_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 134
);
  logic [3:0]          iv_pkt_rd;
  logic [4*ADDR_W-1:0] iv_pkt_raddr;
  logic [3:0]          ov_pkt_raddr_ack;
  logic [DATA_W-1:0]   ov_pkt_data;
  logic [3:0]          ov_pkt_data_wr;
  logic [ADDR_W-1:0]   ov_ram_raddr;
  logic                o_ram_rd;
  logic [DATA_W-1:0]   iv_ram_rdata;

  modport master (
    output iv_pkt_rd, iv_pkt_raddr, iv_ram_rdata,
    input  ov_pkt_raddr_ack, ov_pkt_data, ov_pkt_data_wr, ov_ram_raddr, o_ram_rd
  );

  modport slave (
    input  iv_pkt_rd, iv_pkt_raddr, iv_ram_rdata,
    output ov_pkt_raddr_ack, ov_pkt_data, ov_pkt_data_wr, ov_ram_raddr, o_ram_rd
  );
endinterface

// File: rtl/pkt_read_arbiter.sv
// Round-robin arbiter sharing one packet-buffer RAM read port among 4 output ports.
// Optional per-port grant counters are enabled by defining PKT_RD_ARB_STAT_EN.
module pkt_read_arbiter #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 134
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef PKT_RD_ARB_STAT_EN
  output logic [63:0] ov_grant_cnt,
`endif
  pkt_read_arbiter_if.slave bus
);

  typedef logic [1:0] port_t;

  logic [3:0]        req;
  logic              grant_valid;
  port_t             grant_id;
  port_t             cand;
  port_t             ptr;
  logic [ADDR_W-1:0] port_addr [4];
  logic [RD_LAT-1:0] pipe_valid;
  port_t             pipe_id [RD_LAT];

  // A port whose ack is on the wire still shows rd high this cycle; mask it so it is not granted twice.
  assign req = bus.iv_pkt_rd & ~bus.ov_pkt_raddr_ack;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      port_addr[p] = bus.iv_pkt_raddr[p*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr;
    cand        = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + port_t'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr                  <= 2'd3;
      bus.o_ram_rd         <= 1'b0;
      bus.ov_ram_raddr     <= '0;
      bus.ov_pkt_raddr_ack <= '0;
    end else begin
      bus.o_ram_rd         <= grant_valid;
      bus.ov_pkt_raddr_ack <= grant_valid ? (4'b0001 << grant_id) : 4'b0000;
      if (grant_valid) begin
        ptr              <= grant_id;
        bus.ov_ram_raddr <= port_addr[grant_id];
      end
    end
  end

  // While o_ram_rd is high, ptr still names the port that was just granted, so it doubles as the tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pipe_valid         <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_id[i] <= '0;
      end
      bus.ov_pkt_data    <= '0;
      bus.ov_pkt_data_wr <= '0;
    end else begin
      pipe_valid[0] <= bus.o_ram_rd;
      pipe_id[0]    <= ptr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
      bus.ov_pkt_data_wr <= pipe_valid[RD_LAT-1] ? (4'b0001 << pipe_id[RD_LAT-1]) : 4'b0000;
      if (pipe_valid[RD_LAT-1]) begin
        bus.ov_pkt_data <= bus.iv_ram_rdata;
      end
    end
  end

`ifdef PKT_RD_ARB_STAT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_grant_cnt <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (bus.ov_pkt_raddr_ack[p] && (ov_grant_cnt[p*16 +: 16] != 16'hFFFF)) begin
          ov_grant_cnt[p*16 +: 16] <= ov_grant_cnt[p*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pkt_read_arbiter.sv
// Self-checking bench for pkt_read_arbiter: directed scenarios plus random requesters against a queue-based model.
// Define PKT_RD_ARB_STAT_EN to also check the grant counters.
module tb_pkt_read_arbiter;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 134;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pkt_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef PKT_RD_ARB_STAT_EN
  logic [63:0] grant_cnt;
`endif

  pkt_read_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
`ifdef PKT_RD_ARB_STAT_EN
    .ov_grant_cnt(grant_cnt),
`endif
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    logic [15:0] m7, m13;
    m7  = a * 16'd7;
    m13 = a * 16'd13;
    return {6'h2A, a, ~a, a + 16'h1234, a ^ 16'h5A5A, {a[7:0], a[15:8]}, m7, a + 16'd1, m13};
  endfunction

  // RAM stand-in: returns ram_word(addr) exactly RD_LAT cycles after o_ram_rd, noise otherwise.
  logic [DATA_W-1:0] ram_pipe [RD_LAT];
  logic [159:0]      noise;
  always @(posedge clk) begin
    noise = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = RD_LAT - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
    ram_pipe[0] <= bus.o_ram_rd ? ram_word(bus.ov_ram_raddr) : noise[DATA_W-1:0];
  end
  assign bus.iv_ram_rdata = ram_pipe[RD_LAT-1];

  // Reference model: round-robin search over the last granted port, queue of reads due at grant+RD_LAT+1.
  typedef struct {
    int                port;
    logic [ADDR_W-1:0] addr;
    int                due;
  } rd_t;

  rd_t               inflight[$];
  int                cyc = 0;
  int                last_port;
  int                grants[4];
  logic [3:0]        exp_ack, exp_data_wr;
  logic              exp_rd;
  logic [ADDR_W-1:0] exp_raddr;
  logic [DATA_W-1:0] exp_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight.delete();
      last_port   = 3;
      grants      = '{default: 0};
      exp_ack     = '0;
      exp_rd      = 1'b0;
      exp_raddr   = '0;
      exp_data_wr = '0;
      exp_data    = '0;
    end else begin
      logic [3:0] want;
      int         p;
      rd_t        r;
      want    = bus.iv_pkt_rd & ~exp_ack;
      cyc     = cyc + 1;
      exp_ack = '0;
      exp_rd  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        p = (last_port + k) % 4;
        if (!exp_rd && want[p]) begin
          exp_rd     = 1'b1;
          exp_ack[p] = 1'b1;
          exp_raddr  = bus.iv_pkt_raddr[p*ADDR_W +: ADDR_W];
          last_port  = p;
          inflight.push_back('{p, exp_raddr, cyc + RD_LAT + 1});
          if (grants[p] < 65535) grants[p] = grants[p] + 1;
        end
      end
      exp_data_wr = '0;
      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        r = inflight.pop_front();
        exp_data_wr[r.port] = 1'b1;
        exp_data = ram_word(r.addr);
      end
    end
  end

  logic [158:0] dut_obs, exp_obs;
  assign dut_obs = {bus.ov_pkt_raddr_ack, bus.o_ram_rd, bus.ov_ram_raddr, bus.ov_pkt_data_wr, bus.ov_pkt_data};
  assign exp_obs = {exp_ack, exp_rd, exp_raddr, exp_data_wr, exp_data};

  task automatic apply_reset();
    bus.iv_pkt_rd    = '0;
    bus.iv_pkt_raddr = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (dut_obs !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs c=%0d got=%h want=0", c, dut_obs);
      end
      checks++;
      if (dut_obs !== exp_obs) begin
        errors++;
        $display("[TB] FAIL reset_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
      end
`ifdef PKT_RD_ARB_STAT_EN
      checks++;
      if (grant_cnt !== 64'd0) begin
        errors++;
        $display("[TB] FAIL reset_grant_cnt got=%h want=0", grant_cnt);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    logic [3:0] seen;
    apply_reset();
    bus.iv_pkt_rd[0]        = 1'b1;
    bus.iv_pkt_raddr[15:0]  = 16'h0010;
    for (int c = 0; c <= RD_LAT + 3; c++) begin
      @(negedge clk);
      seen = bus.ov_pkt_raddr_ack;
      checks++;
      if (dut_obs !== exp_obs) begin
        errors++;
        $display("[TB] FAIL single_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
      end
      if (c == 1) begin
        checks++;
        if ({bus.ov_pkt_raddr_ack, bus.o_ram_rd, bus.ov_ram_raddr} !== {4'b0001, 1'b1, 16'h0010}) begin
          errors++;
          $display("[TB] FAIL single_issue got=%h/%b/%h want=1/1/0010",
                   bus.ov_pkt_raddr_ack, bus.o_ram_rd, bus.ov_ram_raddr);
        end
      end
      checks++;
      if (c == RD_LAT + 2) begin
        if (bus.ov_pkt_data_wr !== 4'b0001 || bus.ov_pkt_data !== ram_word(16'h0010)) begin
          errors++;
          $display("[TB] FAIL single_return got=%b/%h want=0001/%h",
                   bus.ov_pkt_data_wr, bus.ov_pkt_data, ram_word(16'h0010));
        end
      end else if (bus.ov_pkt_data_wr !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL single_idle_wr c=%0d got=%b want=0000", c, bus.ov_pkt_data_wr);
      end
      @(posedge clk); #1;
      if (seen[0]) bus.iv_pkt_rd[0] = 1'b0;
    end
  endtask

  task automatic test_all_four();
    logic [3:0] seen, want_ack, want_wr;
    int         k;
    apply_reset();
    for (int p = 0; p < 4; p++) bus.iv_pkt_raddr[p*16 +: 16] = 16'h0100 + 16'(p);
    bus.iv_pkt_rd = 4'hF;
    for (int c = 0; c < RD_LAT + 7; c++) begin
      @(negedge clk);
      seen     = bus.ov_pkt_raddr_ack;
      want_ack = (c >= 1 && c <= 4) ? (4'b0001 << (c - 1)) : 4'b0000;
      k        = c - (RD_LAT + 2);
      want_wr  = (k >= 0 && k <= 3) ? (4'b0001 << k) : 4'b0000;
      checks++;
      if (bus.ov_pkt_raddr_ack !== want_ack) begin
        errors++;
        $display("[TB] FAIL all_four_ack c=%0d got=%b want=%b", c, bus.ov_pkt_raddr_ack, want_ack);
      end
      checks++;
      if (bus.ov_pkt_data_wr !== want_wr) begin
        errors++;
        $display("[TB] FAIL all_four_wr c=%0d got=%b want=%b", c, bus.ov_pkt_data_wr, want_wr);
      end
      checks++;
      if (dut_obs !== exp_obs) begin
        errors++;
        $display("[TB] FAIL all_four_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
      end
      @(posedge clk); #1;
      bus.iv_pkt_rd = bus.iv_pkt_rd & ~seen;
    end
  endtask

  task automatic test_alternate();
    logic [3:0] seen, want_ack;
    apply_reset();
    bus.iv_pkt_raddr[16 +: 16] = 16'h1000;
    bus.iv_pkt_raddr[32 +: 16] = 16'h2000;
    bus.iv_pkt_rd = 4'b0110;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      seen     = bus.ov_pkt_raddr_ack;
      want_ack = (c == 0) ? 4'b0000 : ((c % 2 == 1) ? 4'b0010 : 4'b0100);
      checks++;
      if (bus.ov_pkt_raddr_ack !== want_ack) begin
        errors++;
        $display("[TB] FAIL alternate_ack c=%0d got=%b want=%b", c, bus.ov_pkt_raddr_ack, want_ack);
      end
      checks++;
      if (dut_obs !== exp_obs) begin
        errors++;
        $display("[TB] FAIL alternate_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
      end
      @(posedge clk); #1;
      if (seen[1]) bus.iv_pkt_raddr[16 +: 16] = bus.iv_pkt_raddr[16 +: 16] + 16'd1;
      if (seen[2]) bus.iv_pkt_raddr[32 +: 16] = bus.iv_pkt_raddr[32 +: 16] + 16'd1;
    end
  endtask

  task automatic test_hold();
    logic [3:0] seen;
    int         acks = 0;
    int         reads = 0;
    apply_reset();
    bus.iv_pkt_raddr[48 +: 16] = 16'h3333;
    bus.iv_pkt_rd[3] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen = bus.ov_pkt_raddr_ack;
      if (seen[3]) acks++;
      if (bus.o_ram_rd) reads++;
      checks++;
      if (dut_obs !== exp_obs) begin
        errors++;
        $display("[TB] FAIL hold_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
      end
      @(posedge clk); #1;
      if (seen[3]) bus.iv_pkt_rd[3] = 1'b0;
    end
    checks++;
    if (acks != 1 || reads != 1) begin
      errors++;
      $display("[TB] FAIL hold_single_issue got acks=%0d reads=%0d want 1/1", acks, reads);
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] seen;
    apply_reset();
    bus.iv_pkt_raddr[15:0]  = 16'h00A0;
    bus.iv_pkt_raddr[31:16] = 16'h00B1;
    bus.iv_pkt_rd = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = bus.ov_pkt_raddr_ack;
      @(posedge clk); #1;
      bus.iv_pkt_rd = bus.iv_pkt_rd & ~seen;
    end
    rst = 1'b1;
    bus.iv_pkt_rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < RD_LAT + 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ov_pkt_data_wr !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL midflight_stale_wr c=%0d got=%b want=0000", c, bus.ov_pkt_data_wr);
      end
      @(posedge clk); #1;
    end
    bus.iv_pkt_raddr[15:0]  = 16'h0C00;
    bus.iv_pkt_raddr[31:16] = 16'h0C11;
    bus.iv_pkt_rd = 4'b0011;
    for (int c = 0; c < RD_LAT + 6; c++) begin
      @(negedge clk);
      seen = bus.ov_pkt_raddr_ack;
      if (c == 1) begin
        checks++;
        if (seen !== 4'b0001) begin
          errors++;
          $display("[TB] FAIL midflight_first_grant got=%b want=0001", seen);
        end
      end
      checks++;
      if (dut_obs !== exp_obs) begin
        errors++;
        $display("[TB] FAIL midflight_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
      end
      @(posedge clk); #1;
      bus.iv_pkt_rd = bus.iv_pkt_rd & ~seen;
    end
  endtask

  task automatic test_random();
    logic [3:0] seen;
    apply_reset();
    for (int c = 0; c < 600 + RD_LAT + 4; c++) begin
      @(negedge clk);
      seen = bus.ov_pkt_raddr_ack;
      checks++;
      if (dut_obs !== exp_obs) begin
        errors++;
        $display("[TB] FAIL random_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
      end
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) begin
        if (c >= 600) begin
          bus.iv_pkt_rd[p] = 1'b0;
        end else if (bus.iv_pkt_rd[p] && seen[p]) begin
          bus.iv_pkt_rd[p] = ($urandom_range(99, 0) < 50);
          bus.iv_pkt_raddr[p*16 +: 16] = 16'($urandom());
        end else if (bus.iv_pkt_rd[p]) begin
          if ($urandom_range(99, 0) < 5) bus.iv_pkt_rd[p] = 1'b0;
        end else if ($urandom_range(99, 0) < 40) begin
          bus.iv_pkt_rd[p] = 1'b1;
          bus.iv_pkt_raddr[p*16 +: 16] = 16'($urandom());
        end
      end
    end
    checks++;
    if (inflight.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_drain got=%0d pending want=0", inflight.size());
    end
`ifdef PKT_RD_ARB_STAT_EN
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (grant_cnt[p*16 +: 16] !== 16'(grants[p])) begin
        errors++;
        $display("[TB] FAIL grant_cnt_p%0d got=%0d want=%0d", p, grant_cnt[p*16 +: 16], grants[p]);
      end
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.iv_pkt_rd    = '0;
    bus.iv_pkt_raddr = '0;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_hold();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
